// File: rtl/fetch_queue.sv
// Instruction fetch front end: walks a PC through a combinational instruction
// memory and buffers {pc, instruction} pairs in a small FIFO for decode.
module fetch_queue #(
   parameter int          IMEM_BYTES  = 1024,
   parameter int          QUEUE_DEPTH = 4,
   parameter logic [63:0] RESET_PC    = 64'd0
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [63:0] imem_address,
   input  logic [31:0] imem_instruction,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_pc,
   output logic [31:0] out_instruction,
   output logic        halted
);

   localparam int            PW   = $clog2(QUEUE_DEPTH);
   localparam int            CW   = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

   localparam logic [0:0] RUN  = 1'b0;
   localparam logic [0:0] HALT = 1'b1;

   logic [63:0]   pc;
   logic [0:0]    state;
   logic [CW-1:0] count;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;

   logic [63:0] pc_mem  [QUEUE_DEPTH];
   logic [31:0] ins_mem [QUEUE_DEPTH];

   logic pop;
   logic in_range;
   logic push;

   assign imem_address    = pc;
   assign out_valid       = (count != '0);
   assign out_pc          = pc_mem[head];
   assign out_instruction = ins_mem[head];
   assign halted          = (state == HALT);

   // NOTE: every signal assigned here is assigned on every path, so no latch is inferred.
   always_comb begin
      pop      = out_valid && out_ready;
      in_range = (pc + 64'd3) < 64'(IMEM_BYTES);
      push     = !redirect_valid && (state == RUN) && in_range && ((count != FULL) || pop);
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc    <= RESET_PC;
         state <= RUN;
         count <= '0;
         head  <= '0;
         tail  <= '0;
      end else if (redirect_valid) begin
         // Whatever the head was (taken or not), the whole queue is stale now.
         pc    <= redirect_pc & ~64'd3;
         state <= RUN;
         count <= '0;
         head  <= '0;
         tail  <= '0;
      end else begin
         if (pop) head <= head + PW'(1);
         if (push) begin
            tail <= tail + PW'(1);
            pc   <= pc + 64'd4;
         end
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
         if ((state == RUN) && !in_range) state <= HALT;
      end
   end

   // NOTE: queue storage is deliberately not reset; entries are only read while counted valid.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[tail]  <= pc;
         ins_mem[tail] <= imem_instruction;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; instruction memory word k holds the value k.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [63:0] imem_address;
   logic [31:0] imem_instruction;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [31:0] out_instruction;
   logic        halted;

   int errors = 0;
   int checks = 0;

   fetch_queue dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .imem_address     (imem_address),
      .imem_instruction (imem_instruction),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_pc           (out_pc),
      .out_instruction  (out_instruction),
      .halted           (halted)
   );

   always #5 clk = ~clk;

   assign imem_instruction = 32'(imem_address >> 2);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n        = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'd0;
      out_ready      = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid got=%b exp=0", out_valid);
      end
      checks++;
      if (halted !== 1'b0) begin
         errors++; $display("FAIL reset_halted got=%b exp=0", halted);
      end
      checks++;
      if (imem_address !== 64'd0) begin
         errors++; $display("FAIL reset_pc got=%0d exp=0", imem_address);
      end
   endtask

   task automatic test_stream();
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 64'(4 * i) || out_instruction !== 32'(i)) begin
            errors++;
            $display("FAIL stream[%0d] got v=%b pc=%0d ins=%0d exp v=1 pc=%0d ins=%0d",
                     i, out_valid, out_pc, out_instruction, 4 * i, i);
         end
      end
   endtask

   task automatic test_fill_and_wrap();
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i >= 4) begin
            checks++;
            if (imem_address !== 64'd16) begin
               errors++; $display("FAIL fill_pc_hold[%0d] got=%0d exp=16", i, imem_address);
            end
         end
      end
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'd0) begin
         errors++; $display("FAIL fill_head got v=%b pc=%0d exp v=1 pc=0", out_valid, out_pc);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 64'(4 * k) || out_instruction !== 32'(k)) begin
            errors++;
            $display("FAIL drain[%0d] got v=%b pc=%0d ins=%0d exp v=1 pc=%0d ins=%0d",
                     k, out_valid, out_pc, out_instruction, 4 * k, k);
         end
         tick();
         checks++;
         if (imem_address !== 64'(20 + 4 * k)) begin
            errors++; $display("FAIL full_push_pop[%0d] got=%0d exp=%0d", k, imem_address, 20 + 4 * k);
         end
      end
   endtask

   task automatic test_redirect();
      do_reset();
      out_ready = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (out_valid !== 1'b1 || imem_address !== 64'd12) begin
         errors++; $display("FAIL pre_redirect got v=%b pc=%0d exp v=1 pc=12", out_valid, imem_address);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 64'h103;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || imem_address !== 64'h100) begin
         errors++; $display("FAIL redirect_clear got v=%b pc=%0h exp v=0 pc=100", out_valid, imem_address);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'h100 || out_instruction !== 32'h40) begin
         errors++;
         $display("FAIL redirect_first got v=%b pc=%0h ins=%0h exp v=1 pc=100 ins=40",
                  out_valid, out_pc, out_instruction);
      end
   endtask

   task automatic test_halt();
      do_reset();
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'd1016;
      tick();
      redirect_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 64'(1016 + 4 * k) || out_instruction !== 32'(254 + k)
             || halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_tail[%0d] got v=%b pc=%0d ins=%0d h=%b exp v=1 pc=%0d ins=%0d h=0",
                     k, out_valid, out_pc, out_instruction, halted, 1016 + 4 * k, 254 + k);
         end
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || halted !== 1'b1 || imem_address !== 64'd1024) begin
         errors++;
         $display("FAIL halt_enter got v=%b h=%b pc=%0d exp v=0 h=1 pc=1024", out_valid, halted, imem_address);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || halted !== 1'b1) begin
         errors++; $display("FAIL halt_stay got v=%b h=%b exp v=0 h=1", out_valid, halted);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 64'd0;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (halted !== 1'b0 || out_valid !== 1'b0 || imem_address !== 64'd0) begin
         errors++;
         $display("FAIL halt_exit got h=%b v=%b pc=%0d exp h=0 v=0 pc=0", halted, out_valid, imem_address);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'd0) begin
         errors++; $display("FAIL halt_resume got v=%b pc=%0d exp v=1 pc=0", out_valid, out_pc);
      end
      // Halt with entries still queued: they must drain in order afterwards.
      out_ready      = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 64'd1012;
      tick();
      redirect_valid = 1'b0;
      tick(); tick(); tick(); tick();
      checks++;
      if (halted !== 1'b1 || out_valid !== 1'b1 || out_pc !== 64'd1012) begin
         errors++;
         $display("FAIL halt_queued got h=%b v=%b pc=%0d exp h=1 v=1 pc=1012", halted, out_valid, out_pc);
      end
      out_ready = 1'b1;
      for (int k = 1; k < 3; k++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 64'(1012 + 4 * k)) begin
            errors++;
            $display("FAIL halt_drain[%0d] got v=%b pc=%0d exp v=1 pc=%0d", k, out_valid, out_pc, 1012 + 4 * k);
         end
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || halted !== 1'b1) begin
         errors++; $display("FAIL halt_empty got v=%b h=%b exp v=0 h=1", out_valid, halted);
      end
   endtask

   task automatic test_reset_over_redirect();
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      reset_n        = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h200;
      tick();
      checks++;
      if (imem_address !== 64'd0 || out_valid !== 1'b0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL reset_wins got pc=%0h v=%b h=%b exp pc=0 v=0 h=0", imem_address, out_valid, halted);
      end
      reset_n        = 1'b1;
      redirect_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'd0) begin
         errors++; $display("FAIL reset_restart got v=%b pc=%0d exp v=1 pc=0", out_valid, out_pc);
      end
   endtask

   initial begin
      reset_n        = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'd0;
      out_ready      = 1'b0;
      test_reset();
      test_stream();
      test_fill_and_wrap();
      test_redirect();
      test_halt();
      test_reset_over_redirect();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
